scan_ctrl: RTL and testbench

Control FSM that sequences the 8-bit `datapath` (y register, 3-bit index s, bit-select b = y[s]). It accepts a command over a start/done handshake and drives the datapath control inputs cycle by cycle. It reads back `s` and `b` to locate the highest set bit of y and reports the result. It sits directly upstream of `datapath`, and its control outputs connect 1:1 to the datapath inputs of the same name.

---
 rtl/scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_scan_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_ctrl.sv
// scan_ctrl: control FSM sequencing an 8-bit y / 3-bit s datapath.
// Accepts a command on start (sampled only in IDLE) and drives the datapath
// controls cycle by cycle. LOAD copies x into y, INC increments y, SCAN walks
// s from 7 down to find the highest set bit of y, and SCAN_ADD additionally
// adds the found index to y.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, cmd[1:0] command request / opcode (0 LOAD, 1 INC, 2 SCAN, 3 SCAN_ADD)
//   s[2:0], b       datapath index feedback and bit feedback (y[s])
//   abort           early termination, present only with SCAN_CTRL_ABORT_EN
//   busy, done      state != IDLE / one-cycle pulse in DONE
//   found, idx[2:0] registered result of the last completed scan
//   s_en, s_sub, s_zero, s_step[1:0], y_en, y_upd, y_select_next[1:0]
//                   datapath controls (combinational from state, s and b)
// Build option: define SCAN_CTRL_ABORT_EN to add the abort input.
module scan_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [2:0] s,
  input  logic       b,
`ifdef SCAN_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic [2:0] idx,
  output logic       s_en,
  output logic       s_sub,
  output logic       s_zero,
  output logic [1:0] s_step,
  output logic       y_en,
  output logic       y_upd,
  output logic [1:0] y_select_next
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INC   = 3'd2,
    ST_SINIT = 3'd3,
    ST_SCAN  = 3'd4,
    ST_ADD   = 3'd5,
    ST_DONE  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    CMD_LOAD     = 2'd0,
    CMD_INC      = 2'd1,
    CMD_SCAN     = 2'd2,
    CMD_SCAN_ADD = 2'd3
  } cmd_t;

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic       found_q, found_d;
  logic [2:0] idx_q, idx_d;
  logic       abort_w;

`ifdef SCAN_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_LOAD;
      found_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      found_q <= found_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    found_d       = found_q;
    idx_d         = idx_q;
    s_en          = 1'b0;
    s_sub         = 1'b0;
    s_zero        = 1'b0;
    s_step        = '0;
    y_en          = 1'b0;
    y_upd         = 1'b0;
    y_select_next = '0;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          cmd_d = cmd_t'(cmd);
          unique case (cmd_t'(cmd))
            CMD_LOAD: state_d = ST_LOAD;
            CMD_INC:  state_d = ST_INC;
            default:  state_d = ST_SINIT;
          endcase
        end
      end
      ST_LOAD: begin
        y_en    = 1'b1;
        state_d = ST_DONE;
      end
      ST_INC: begin
        y_en          = 1'b1;
        y_upd         = 1'b1;
        y_select_next = 2'd3;
        state_d       = ST_DONE;
      end
      ST_SINIT: begin
        // 0 - 1 wraps s to 7, the first index examined
        s_en    = 1'b1;
        s_zero  = 1'b1;
        s_sub   = 1'b1;
        s_step  = 2'd1;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (b) begin
          found_d = 1'b1;
          idx_d   = s;
          state_d = (cmd_q == CMD_SCAN_ADD) ? ST_ADD : ST_DONE;
        end else if (s == 3'd0) begin
          found_d = 1'b0;
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          s_en   = 1'b1;
          s_sub  = 1'b1;
          s_step = 2'd1;
        end
      end
      ST_ADD: begin
        y_en          = 1'b1;
        y_upd         = 1'b1;
        y_select_next = 2'd1;
        state_d       = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the exec state computed above, including a
    // scan hit in the same cycle: idx keeps its old value, found clears.
    if (abort_w && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      s_en          = 1'b0;
      s_sub         = 1'b0;
      s_zero        = 1'b0;
      s_step        = '0;
      y_en          = 1'b0;
      y_upd         = 1'b0;
      y_select_next = '0;
      found_d       = 1'b0;
      idx_d         = idx_q;
      state_d       = ST_DONE;
    end
  end

  assign found = found_q;
  assign idx   = idx_q;

endmodule

// File: tb/tb_scan_ctrl.sv
module tb_scan_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] cmd;
  logic [2:0] s;
  logic       b;
  logic       abort;
  logic       busy, done, found;
  logic [2:0] idx;
  logic       s_en, s_sub, s_zero, y_en, y_upd;
  logic [1:0] s_step, y_select_next;

  // datapath stand-in
  logic [7:0] x;
  logic [7:0] y;
  logic [2:0] s_base;

  int total;
  int bad;

  // per-cycle control log of the most recent command, {s_en,s_sub,s_zero,y_en,y_upd,s_step,y_sel}
  logic [8:0] clog [0:63];
  int         done_cyc;

  scan_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cmd           (cmd),
    .s             (s),
    .b             (b),
`ifdef SCAN_CTRL_ABORT_EN
    .abort         (abort),
`endif
    .busy          (busy),
    .done          (done),
    .found         (found),
    .idx           (idx),
    .s_en          (s_en),
    .s_sub         (s_sub),
    .s_zero        (s_zero),
    .s_step        (s_step),
    .y_en          (y_en),
    .y_upd         (y_upd),
    .y_select_next (y_select_next)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign b      = y[s];
  assign s_base = s_zero ? 3'd0 : s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y <= '0;
      s <= '0;
    end else begin
      if (s_en) s <= s_sub ? (s_base - {1'b0, s_step}) : (s_base + {1'b0, s_step});
      if (y_en) begin
        if (!y_upd) y <= x;
        else case (y_select_next)
          2'd1:    y <= y + {5'd0, s};
          2'd3:    y <= y + 8'd1;
          default: y <= y;
        endcase
      end
    end
  end

  function automatic logic [8:0] ctl_now();
    return {s_en, s_sub, s_zero, y_en, y_upd, s_step, y_select_next};
  endfunction

  // Issue one command; cycle 0 is the accepting edge. Logs controls per cycle
  // and records the cycle in which done is seen (-1 on timeout). Returns in IDLE.
  task automatic run_cmd(input logic [1:0] c);
    int n;
    for (int i = 0; i < 64; i++) clog[i] = '0;
    done_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    cmd   = c;
    @(posedge clk);
    #1 start = 1'b0;
    n = 1;
    while (n < 40) begin
      @(negedge clk);
      clog[n] = ctl_now();
      if (done) begin
        done_cyc = n;
        break;
      end
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    x = v;
    run_cmd(2'd0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL reset_found got=%0b exp=0", found); end
    total++; if (idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", idx); end
    total++; if (ctl_now() !== 9'd0) begin bad++; $display("FAIL reset_ctl got=%b exp=0", ctl_now()); end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load;
    do_load(8'hA5);
    total++; if (clog[1] !== 9'b000100000) begin bad++; $display("FAIL load_ctl_c1 got=%b exp=000100000", clog[1]); end
    total++; if (done_cyc !== 2) begin bad++; $display("FAIL load_done_cycle got=%0d exp=2", done_cyc); end
    total++; if (y !== 8'hA5) begin bad++; $display("FAIL load_y got=%h exp=a5", y); end
    total++; if (found !== 1'b0 || idx !== 3'd0) begin bad++; $display("FAIL load_keep_result got=%0b/%0d exp=0/0", found, idx); end
  endtask

  task automatic test_scan_msb;
    do_load(8'h80);
    run_cmd(2'd2);
    total++; if (clog[1] !== 9'b111000100) begin bad++; $display("FAIL sinit_ctl got=%b exp=111000100", clog[1]); end
    total++; if (done_cyc !== 3) begin bad++; $display("FAIL scan80_done_cycle got=%0d exp=3", done_cyc); end
    total++; if (found !== 1'b1 || idx !== 3'd7) begin bad++; $display("FAIL scan80_result got=%0b/%0d exp=1/7", found, idx); end
    total++; if (s !== 3'd7) begin bad++; $display("FAIL scan80_s got=%0d exp=7", s); end
  endtask

  task automatic test_scan_lsb;
    do_load(8'h01);
    run_cmd(2'd2);
    total++; if (done_cyc !== 10) begin bad++; $display("FAIL scan01_done_cycle got=%0d exp=10", done_cyc); end
    total++; if (found !== 1'b1 || idx !== 3'd0) begin bad++; $display("FAIL scan01_result got=%0b/%0d exp=1/0", found, idx); end
    total++; if (y !== 8'h01) begin bad++; $display("FAIL scan01_y got=%h exp=01", y); end
  endtask

  task automatic test_scan_add;
    do_load(8'h24);
    run_cmd(2'd3);
    total++; if (clog[4] !== 9'd0) begin bad++; $display("FAIL sadd_hit_ctl got=%b exp=0", clog[4]); end
    total++; if (clog[5] !== 9'b000110001) begin bad++; $display("FAIL sadd_add_ctl got=%b exp=000110001", clog[5]); end
    total++; if (done_cyc !== 6) begin bad++; $display("FAIL sadd_done_cycle got=%0d exp=6", done_cyc); end
    total++; if (y !== 8'h29) begin bad++; $display("FAIL sadd_y got=%h exp=29", y); end
    total++; if (found !== 1'b1 || idx !== 3'd5) begin bad++; $display("FAIL sadd_result got=%0b/%0d exp=1/5", found, idx); end
    // LOAD then INC must leave the scan result and s alone
    do_load(8'h10);
    run_cmd(2'd1);
    total++; if (found !== 1'b1 || idx !== 3'd5) begin bad++; $display("FAIL hold_result got=%0b/%0d exp=1/5", found, idx); end
    total++; if (s !== 3'd5) begin bad++; $display("FAIL hold_s got=%0d exp=5", s); end
    total++; if (y !== 8'h11) begin bad++; $display("FAIL hold_y got=%h exp=11", y); end
  endtask

  task automatic test_no_hit_inc;
    do_load(8'h00);
    run_cmd(2'd2);
    total++; if (done_cyc !== 10) begin bad++; $display("FAIL nohit_done_cycle got=%0d exp=10", done_cyc); end
    total++; if (found !== 1'b0 || idx !== 3'd0) begin bad++; $display("FAIL nohit_result got=%0b/%0d exp=0/0", found, idx); end
    total++; if (s !== 3'd0) begin bad++; $display("FAIL nohit_s got=%0d exp=0", s); end
    run_cmd(2'd1);
    total++; if (clog[1] !== 9'b000110011) begin bad++; $display("FAIL inc_ctl got=%b exp=000110011", clog[1]); end
    total++; if (done_cyc !== 2 || y !== 8'h01) begin bad++; $display("FAIL inc_y got=%0d/%h exp=2/01", done_cyc, y); end
    do_load(8'hFF);
    run_cmd(2'd1);
    total++; if (y !== 8'h00) begin bad++; $display("FAIL inc_wrap got=%h exp=00", y); end
  endtask

  // start held high through the whole command: DONE must not re-accept it
  task automatic test_back_to_back;
    do_load(8'h40);
    @(negedge clk);
    start = 1'b1;
    cmd   = 2'd1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy_c1 got=%0b exp=1", busy); end
    @(posedge clk); #1;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL b2b_done_c2 got=%0b exp=1", done); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_c3 got=%0b exp=0", busy); end
    @(posedge clk); #1;
    start = 1'b0;
    total++; if (busy !== 1'b1 || y_en !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got=%0b/%0b exp=1/1", busy, y_en); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++; if (y !== 8'h42) begin bad++; $display("FAIL b2b_y got=%h exp=42", y); end
  endtask

`ifdef SCAN_CTRL_ABORT_EN
  task automatic test_abort;
    int n;
    do_load(8'h01);
    @(negedge clk);
    start = 1'b1;
    cmd   = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(negedge clk);
    total++; if (ctl_now() !== 9'd0) begin bad++; $display("FAIL abort_ctl got=%b exp=0", ctl_now()); end
    @(posedge clk); #1;
    abort = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_done_c5 got=%0b exp=1", done); end
    total++; if (found !== 1'b0) begin bad++; $display("FAIL abort_found got=%0b exp=0", found); end
    n = 0;
    while (busy && n < 10) begin @(posedge clk); #1; n++; end
  endtask
`endif

  task automatic test_reset_mid;
    do_load(8'h80);
    run_cmd(2'd2);
    do_load(8'h01);
    @(negedge clk);
    start = 1'b1;
    cmd   = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rstmid_idle got=%0b/%0b exp=0/0", busy, done); end
    total++; if (found !== 1'b0 || idx !== 3'd0) begin bad++; $display("FAIL rstmid_result got=%0b/%0d exp=0/0", found, idx); end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_stays_idle got=%0b exp=0", busy); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    start = 1'b0;
    cmd   = '0;
    abort = 1'b0;
    x     = '0;
    rst   = 1'b1;
    test_reset;
    test_load;
    test_scan_msb;
    test_scan_lsb;
    test_scan_add;
    test_no_hit_inc;
    test_back_to_back;
`ifdef SCAN_CTRL_ABORT_EN
    test_abort;
`endif
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
